// File: rtl/echo_pipe_pkg.sv
// Shared definitions for the Echo request/indication pipe.
//   - tag constants for say / say2
//   - bit offsets of the tag, meth, v and v2 fields inside a 128-bit message
//   - 128-bit message typedef and driver state enum
//   - make_request: builds the request message for a given request index
//   - sat_inc: 32-bit saturating increment
package echo_pipe_pkg;

    localparam int unsigned MSG_W   = 128;
    localparam int unsigned FIELD_W = 32;

    localparam logic [31:0] TAG_SAY2 = 32'd1;
    localparam logic [31:0] TAG_SAY  = 32'd2;

    localparam int unsigned TAG_LSB  = 0;
    localparam int unsigned METH_LSB = 32;
    localparam int unsigned V_LSB    = 64;
    localparam int unsigned V2_LSB   = 96;

    typedef logic [MSG_W-1:0] echo_msg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drv_state_t;

    // Even indices are say (v2 = 0), odd indices are say2 (v2 = ~v).
    function automatic echo_msg_t make_request(input logic [31:0] idx,
                                               input logic [31:0] seed);
        echo_msg_t   msg;
        logic [31:0] val;
        val = seed + idx;
        msg = '0;
        msg[TAG_LSB  +: FIELD_W] = idx[0] ? TAG_SAY2 : TAG_SAY;
        msg[METH_LSB +: FIELD_W] = idx;
        msg[V_LSB    +: FIELD_W] = val;
        msg[V2_LSB   +: FIELD_W] = idx[0] ? ~val : '0;
        return msg;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == '1) ? x : x + 32'd1;
    endfunction

endpackage

// File: rtl/echo_expect_fifo.sv
// Expected-message queue for the echo driver.
// DEPTH x WIDTH synchronous FIFO; DEPTH must be a power of two (pointers wrap
// naturally). flush empties the queue and overrides push/pop in that cycle.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              discard all entries
//   push, push_data    write one entry (ignored when full)
//   pop                drop the head entry (ignored when empty)
//   head               current head entry (valid when !empty)
//   full, empty        occupancy flags
module echo_expect_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;
    logic             do_push;
    logic             do_pop;

    assign full    = (fill == (AW+1)'(DEPTH));
    assign empty   = (fill == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                fill <= fill + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                fill <= fill - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/echo_request_driver.sv
// Hardware initiator for the Echo request/indication protocol.
// Sends start_count say/say2 requests, keeps each sent message in an in-order
// expected queue and checks returning indications against its head.
// Optional watchdog: define ECHO_DRIVER_TIMEOUT_EN.
module echo_request_driver
  import echo_pipe_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter logic [31:0] SEED           = 32'h100,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         start__ENA,
  input  logic [31:0]  start_count,
  output logic         start__RDY,
  output logic         request_enq__ENA,
  output logic [127:0] request_enq_v,
  input  logic         request_enq__RDY,
  input  logic         indication_enq__ENA,
  input  logic [127:0] indication_enq_v,
  output logic         indication_enq__RDY,
  output logic         done,
  output logic [31:0]  pass_count,
  output logic [31:0]  err_count,
  output logic         timeout
);

  drv_state_t  state_q;
  drv_state_t  state_d;
  logic [31:0] count_q;
  logic [31:0] sent_q;
  logic [31:0] pass_q;
  logic [31:0] err_q;
  logic        start_acc;
  logic        req_ena;
  logic        fire;
  echo_msg_t   req_msg;
  logic        fifo_flush;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  echo_msg_t   fifo_head;
  logic        ind_match;

  assign start_acc = start__ENA && start__RDY;
  assign req_msg   = make_request(sent_q, SEED);
  assign fifo_pop  = indication_enq__ENA && !fifo_empty;
  assign ind_match = (fifo_head == indication_enq_v);

  echo_expect_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_W)
  ) u_expect (
    .clk       (CLK),
    .rst_n     (nRST),
    .flush     (fifo_flush),
    .push      (req_ena),
    .push_data (req_msg),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start__RDY = 1'b0;
    req_ena    = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        start__RDY = 1'b1;
        if (start__ENA) begin
          state_d    = RUN;
          fifo_flush = 1'b1;
        end
      end
      RUN: begin
        // No new request on the cycle the watchdog flushes the queue.
        req_ena = (sent_q < count_q) && !fifo_full && request_enq__RDY && !fire;
        if (fire) begin
          state_d    = DONE;
          fifo_flush = 1'b1;
        end else if ((sent_q == count_q) && fifo_empty) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An indication landing on the start cycle is discarded with the old run.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
      sent_q  <= '0;
      pass_q  <= '0;
      err_q   <= '0;
    end else if (start_acc) begin
      count_q <= start_count;
      sent_q  <= '0;
      pass_q  <= '0;
      err_q   <= '0;
    end else begin
      if (req_ena) begin
        sent_q <= sent_q + 32'd1;
      end
      if (indication_enq__ENA) begin
        if (!fifo_empty && ind_match) begin
          pass_q <= sat_inc(pass_q);
        end else begin
          err_q <= sat_inc(err_q);
        end
      end
    end
  end

`ifdef ECHO_DRIVER_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        wd_active;
  logic        timeout_q;

  assign wd_active = (state_q == RUN) && !fifo_empty && !indication_enq__ENA;
  assign fire      = wd_active && ((wd_q + 32'd1) == TIMEOUT_CYCLES[31:0]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (start_acc) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (indication_enq__ENA) begin
        wd_q <= '0;
      end else if (wd_active) begin
        wd_q <= wd_q + 32'd1;
      end
      if (fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif

  assign request_enq__ENA    = req_ena;
  assign request_enq_v       = req_ena ? req_msg : '0;
  assign indication_enq__RDY = 1'b1;
  assign done                = (state_q == DONE);
  assign pass_count          = pass_q;
  assign err_count           = err_q;

endmodule

// File: tb/tb_echo_request_driver.sv
// Bench for echo_request_driver: a loopback responder with programmable
// latency/corruption, a queue-based model of the driver and a negedge
// compare process, plus literal checks at key points of each scenario.
// Build with ECHO_DRIVER_TIMEOUT_EN defined to exercise the watchdog.
module tb_echo_request_driver;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] SEED  = 32'h100;
  localparam int unsigned TO    = 50;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start_ena = 1'b0;
  logic [31:0]  start_count = '0;
  logic         start_rdy;
  logic         req_ena_o;
  logic [127:0] req_v;
  logic         req_rdy = 1'b1;
  logic         ind_ena = 1'b0;
  logic [127:0] ind_v = '0;
  logic         ind_rdy;
  logic         done;
  logic [31:0]  pass_count;
  logic [31:0]  err_count;
  logic         timeout;

  int n_vec = 0;
  int n_miss = 0;

  echo_request_driver #(
    .DEPTH          (DEPTH),
    .SEED           (SEED),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK                 (clk),
    .nRST                (nrst),
    .start__ENA          (start_ena),
    .start_count         (start_count),
    .start__RDY          (start_rdy),
    .request_enq__ENA    (req_ena_o),
    .request_enq_v       (req_v),
    .request_enq__RDY    (req_rdy),
    .indication_enq__ENA (ind_ena),
    .indication_enq_v    (ind_v),
    .indication_enq__RDY (ind_rdy),
    .done                (done),
    .pass_count          (pass_count),
    .err_count           (err_count),
    .timeout             (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit           m_running = 0;
  bit           m_done = 0;
  bit           m_timeout = 0;
  logic [31:0]  m_count = '0;
  logic [31:0]  m_sent = '0;
  logic [31:0]  m_pass = '0;
  logic [31:0]  m_err = '0;
  logic [31:0]  m_wd = '0;
  logic [127:0] m_q[$];

  function automatic logic [127:0] exp_msg(input logic [31:0] i);
    logic [31:0] v;
    v = SEED + i;
    if (i % 2 == 0) return {32'h0, v, i, 32'd2};
    else            return {~v, v, i, 32'd1};
  endfunction

  function automatic bit pred_fire();
`ifdef ECHO_DRIVER_TIMEOUT_EN
    return m_running && (m_q.size() != 0) && !ind_ena && (m_wd + 32'd1 == TO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit pred_ena();
    return m_running && (m_sent < m_count) && (m_q.size() < DEPTH) && req_rdy && !pred_fire();
  endfunction

  function automatic logic [31:0] inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 1;
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      m_running = 0; m_done = 0; m_timeout = 0;
      m_count = '0; m_sent = '0; m_pass = '0; m_err = '0; m_wd = '0;
      m_q.delete();
    end else begin
      bit ena, fire, finish, had_entries;
      ena = pred_ena();
      fire = pred_fire();
      if (start_ena && !m_running) begin
        m_running = 1; m_done = 0; m_timeout = 0;
        m_count = start_count; m_sent = '0; m_pass = '0; m_err = '0; m_wd = '0;
        m_q.delete();
      end else begin
        finish = m_running && (m_sent == m_count) && (m_q.size() == 0);
        had_entries = (m_q.size() != 0);
        if (ind_ena) begin
          if (m_q.size() == 0) m_err = inc(m_err);
          else begin
            if (m_q[0] === ind_v) m_pass = inc(m_pass);
            else m_err = inc(m_err);
            void'(m_q.pop_front());
          end
        end
        if (ena) begin
          m_q.push_back(exp_msg(m_sent));
          m_sent = m_sent + 1;
        end
        if (ind_ena) m_wd = '0;
        else if (m_running && had_entries) m_wd = m_wd + 1;
        if (fire) begin
          m_timeout = 1; m_running = 0; m_done = 1; m_q.delete();
        end else if (finish) begin
          m_running = 0; m_done = 1;
        end
      end
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_req_ena", req_ena_o, 0);
      chk("rst_req_v", req_v, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_ind_rdy", ind_rdy, 1);
      chk("rst_start_rdy", start_rdy, 1);
    end else begin
      bit e;
      e = pred_ena();
      chk("start_rdy", start_rdy, !m_running);
      chk("req_ena", req_ena_o, e);
      if (e) chk("req_v", req_v, exp_msg(m_sent));
      chk("ind_rdy", ind_rdy, 1);
      chk("done", done, m_done);
      chk("pass_count", pass_count, m_pass);
      chk("err_count", err_count, m_err);
      chk("timeout", timeout, m_timeout);
    end
  end

  // ---------------- responder ----------------
  int           cyc = 0;
  bit           resp_en = 1;
  int           resp_lat = 1;
  logic [31:0]  corrupt_meth = 32'hFFFF_FFFF;
  int           n_pulses = 0;
  logic [127:0] cap[$];
  logic [127:0] resp_msg[$];
  int           resp_due[$];

  always @(negedge clk) begin
    if (req_ena_o) begin
      logic [127:0] m;
      n_pulses++;
      cap.push_back(req_v);
      if (resp_en) begin
        m = req_v;
        if (m[63:32] == corrupt_meth) m[95:64] = 32'h999;
        resp_msg.push_back(m);
        resp_due.push_back(cyc + resp_lat);
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (resp_msg.size() != 0 && resp_due[0] <= cyc) begin
      ind_ena = 1'b1;
      ind_v = resp_msg.pop_front();
      void'(resp_due.pop_front());
    end else begin
      ind_ena = 1'b0;
      ind_v = '0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    nrst = 1'b0;
    repeat (2) step();
    nrst = 1'b1;
  endtask

  task automatic start_run(input logic [31:0] n);
    step();
    start_ena = 1'b1;
    start_count = n;
    step();
    start_ena = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] lit[4];
    int base;
    int p0;
    lit[0] = 128'h00000000_00000100_00000000_00000002;
    lit[1] = 128'hFFFFFEFE_00000101_00000001_00000001;
    lit[2] = 128'h00000000_00000102_00000002_00000002;
    lit[3] = 128'hFFFFFEFC_00000103_00000003_00000001;

    repeat (3) step();
    nrst = 1'b1;

    // Loopback, count=4
    base = cap.size();
    start_run(4);
    wait_done(200, "loop4_done");
    chk("loop4_pass", pass_count, 4);
    chk("loop4_err", err_count, 0);
    for (int i = 0; i < 4; i++) chk("loop4_msg", cap[base + i], lit[i]);

    // Backpressure window, count=6
    base = cap.size();
    start_run(6);
    repeat (2) step();
    req_rdy = 1'b0;
    p0 = n_pulses;
    repeat (10) step();
    chk("rdy_low_no_ena", n_pulses - p0, 0);
    req_rdy = 1'b1;
    wait_done(200, "bp6_done");
    chk("bp6_pass", pass_count, 6);
    chk("bp6_err", err_count, 0);
    chk("bp6_sent", cap.size() - base, 6);
    for (int i = 0; i < 6; i++) chk("bp6_order", cap[base + i][63:32], i);

    // Corrupted echo of request 2
    corrupt_meth = 32'd2;
    start_run(4);
    wait_done(200, "bad_done");
    chk("bad_pass", pass_count, 3);
    chk("bad_err", err_count, 1);
    corrupt_meth = 32'hFFFF_FFFF;

    // Unexpected indication in IDLE
    do_reset();
    resp_msg.push_back(128'h1234);
    resp_due.push_back(cyc);
    repeat (3) step();
    chk("idle_ind_err", err_count, 1);
    chk("idle_ind_pass", pass_count, 0);
    chk("idle_ind_rdy", ind_rdy, 1);
    chk("idle_done", done, 0);

    // No responder, count=8: queue fills and the run stalls
    resp_en = 0;
    p0 = n_pulses;
    start_run(8);
    repeat (70) step();
    chk("stall_pulses", n_pulses - p0, 4);
`ifdef ECHO_DRIVER_TIMEOUT_EN
    chk("stall_timeout", timeout, 1);
    chk("stall_done", done, 1);
`else
    chk("stall_timeout", timeout, 0);
    chk("stall_done", done, 0);
`endif
    resp_en = 1;

    // count=0
    do_reset();
    start_run(0);
    @(negedge clk);
    chk("zero_done_early", done, 0);
    step();
    @(negedge clk);
    chk("zero_done", done, 1);

    // Reset in the middle of a run with echoes still in flight
    resp_lat = 4;
    start_run(8);
    repeat (5) step();
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_req_ena", req_ena_o, 0);
    chk("async_req_v", req_v, 0);
    chk("async_done", done, 0);
    chk("async_pass", pass_count, 0);
    chk("async_err", err_count, 0);
    chk("async_start_rdy", start_rdy, 1);
    chk("async_ind_rdy", ind_rdy, 1);
    chk("async_timeout", timeout, 0);
    repeat (2) step();
    nrst = 1'b1;
    repeat (15) step();
    chk("orphan_errs", err_count != 0, 1);
    chk("orphan_pass", pass_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
